// File: rtl/seq_mult_param_pkg.sv
// mult_pkg: shared definitions for the parametrised shift-add multiplier.
//   - state_e       : controller states (IDLE, RUN)
//   - clog2()       : ceiling log2 for sizing the iteration counter
//   - DEFAULT_WIDTH : operand width used when no override is given
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of bits needed to hold values 0 .. value-1 (minimum 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: operand/result handshake bundle for seq_mult_param.
//   start, abort, md, mr : requester -> multiplier
//   busy, done, product, sign : multiplier -> requester/display
// Modports: master (operand source), slave (multiplier).
interface seq_mult_param_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                   start;
  logic                   abort;
  logic [WIDTH-1:0]       md;
  logic [WIDTH-1:0]       mr;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   sign;

  modport master (
    output start, abort, md, mr,
    input  busy, done, product, sign
  );

  modport slave (
    input  start, abort, md, mr,
    output busy, done, product, sign
  );

endinterface

// File: rtl/seq_mult_param_twos_mag.sv
// twos_mag: combinational magnitude/sign split of a WIDTH-bit operand.
//   x_i   : operand
//   mag_o : |x_i| as an unsigned WIDTH-bit value (most-negative maps to 2^(WIDTH-1))
//   neg_o : operand sign (always 0 when SIGNED=0)
module twos_mag #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             neg_o
);

  assign neg_o = (SIGNED != 0) ? x_i[WIDTH-1] : 1'b0;
  // Two's-complement negate; the most-negative value negates to itself,
  // which read as unsigned is exactly its magnitude.
  assign mag_o = neg_o ? ((~x_i) + WIDTH'(1)) : x_i;

endmodule

// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised shift-add sequential multiplier.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_mult_param_if.slave
//          start/md/mr sampled in IDLE, abort cancels a running operation,
//          busy high in RUN, done one-cycle pulse with product/sign updated.
// Operands are multiplied as magnitudes; the sign is reapplied to the result
// on the terminating edge. With EARLY_TERM the loop stops once no multiplier
// bits remain, so latency tracks the position of the highest set bit of |mr|.
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SIGNED     = 1,
  parameter int EARLY_TERM = 1
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_param_if.slave   bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   product_q, product_d;
  logic            sign_q, sign_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] md_mag, mr_mag;
  logic             md_neg, mr_neg;
  logic             term;

  twos_mag #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_md_mag (
    .x_i   (bus.md),
    .mag_o (md_mag),
    .neg_o (md_neg)
  );

  twos_mag #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_mr_mag (
    .x_i   (bus.mr),
    .mag_o (mr_mag),
    .neg_o (mr_neg)
  );

  assign term = ((EARLY_TERM != 0) && (mplr_q == '0)) || (cnt_q == CW'(WIDTH));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    sign_d    = sign_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = {{WIDTH{1'b0}}, md_mag};
          mplr_d  = mr_mag;
          neg_d   = md_neg ^ mr_neg;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (term) begin
          product_d = neg_q ? ({PW{1'b0}} - acc_q) : acc_q;
          sign_d    = neg_q && (acc_q != '0);
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      sign_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      sign_q    <= sign_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.sign    = sign_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed bench for seq_mult_param.
// Three 8-bit instances (signed/early, unsigned/early, signed/full-length)
// share one stimulus; a 16-bit signed/early instance has its own.
module tb_seq_mult_param;

  logic clk;
  logic rst;

  logic       start8, abort8;
  logic [7:0] md8, mr8;
  logic       start16;
  logic [15:0] md16, mr16;

  seq_mult_param_if #(.WIDTH(8))  bus_a ();
  seq_mult_param_if #(.WIDTH(8))  bus_b ();
  seq_mult_param_if #(.WIDTH(8))  bus_c ();
  seq_mult_param_if #(.WIDTH(16)) bus_w ();

  seq_mult_param #(.WIDTH(8),  .SIGNED(1), .EARLY_TERM(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_mult_param #(.WIDTH(8),  .SIGNED(0), .EARLY_TERM(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  seq_mult_param #(.WIDTH(8),  .SIGNED(1), .EARLY_TERM(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  seq_mult_param #(.WIDTH(16), .SIGNED(1), .EARLY_TERM(1)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  assign bus_a.start = start8;  assign bus_a.abort = abort8; assign bus_a.md = md8;  assign bus_a.mr = mr8;
  assign bus_b.start = start8;  assign bus_b.abort = abort8; assign bus_b.md = md8;  assign bus_b.mr = mr8;
  assign bus_c.start = start8;  assign bus_c.abort = abort8; assign bus_c.md = md8;  assign bus_c.mr = mr8;
  assign bus_w.start = start16; assign bus_w.abort = 1'b0;   assign bus_w.md = md16; assign bus_w.mr = mr16;

  logic        d_busy [4];
  logic        d_done [4];
  logic        d_sign [4];
  logic [31:0] d_prod [4];

  assign d_busy[0] = bus_a.busy; assign d_done[0] = bus_a.done; assign d_sign[0] = bus_a.sign; assign d_prod[0] = {16'h0, bus_a.product};
  assign d_busy[1] = bus_b.busy; assign d_done[1] = bus_b.done; assign d_sign[1] = bus_b.sign; assign d_prod[1] = {16'h0, bus_b.product};
  assign d_busy[2] = bus_c.busy; assign d_done[2] = bus_c.done; assign d_sign[2] = bus_c.sign; assign d_prod[2] = {16'h0, bus_c.product};
  assign d_busy[3] = bus_w.busy; assign d_done[3] = bus_w.done; assign d_sign[3] = bus_w.sign; assign d_prod[3] = bus_w.product;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer multiply on the interpreted operands, plus the
  // iteration count implied by the operand-width / early-termination rule.
  function automatic void ref_mult(input int w, input bit sgn, input bit et,
                                   input longint a_raw, input longint b_raw,
                                   output longint prod, output bit s, output int k);
    longint a, b, p, mb;
    a = a_raw;
    b = b_raw;
    if (sgn && a_raw[w-1]) a = a_raw - (longint'(1) << w);
    if (sgn && b_raw[w-1]) b = b_raw - (longint'(1) << w);
    p    = a * b;
    prod = p & ((longint'(1) << (2 * w)) - 1);
    s    = (p < 0);
    mb   = (b < 0) ? -b : b;
    k    = 0;
    if (et) begin
      for (int i = 0; i < w; i++) if (mb[i]) k = i + 1;
    end else begin
      k = w;
    end
  endfunction

  // Per-instance configuration and cycle-level expectation.
  int     cfg_w [4] = '{8, 8, 8, 16};
  bit     cfg_s [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit     cfg_e [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit     m_busy [4];
  bit     m_done [4];
  bit     m_sign [4];
  bit     p_sign [4];
  longint m_prod [4];
  longint p_prod [4];
  int     m_rem  [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_sign[d] = 1'b0;
        m_prod[d] = 0;    m_rem[d]  = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        bit     st, ab;
        longint a, b;
        int     k;
        if (d < 3) begin st = start8;  ab = abort8; a = longint'(md8);  b = longint'(mr8);  end
        else       begin st = start16; ab = 1'b0;   a = longint'(md16); b = longint'(mr16); end
        m_done[d] = 1'b0;
        if (m_busy[d]) begin
          if (ab) begin
            m_busy[d] = 1'b0;
          end else if (m_rem[d] == 0) begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
            m_prod[d] = p_prod[d];
            m_sign[d] = p_sign[d];
          end else begin
            m_rem[d] = m_rem[d] - 1;
          end
        end else if (st) begin
          ref_mult(cfg_w[d], cfg_s[d], cfg_e[d], a, b, p_prod[d], p_sign[d], k);
          m_rem[d]  = k;
          m_busy[d] = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  int ndone0 = 0;
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      check($sformatf("cyc dut%0d busy", d), 64'(d_busy[d]), 64'(m_busy[d]));
      check($sformatf("cyc dut%0d done", d), 64'(d_done[d]), 64'(m_done[d]));
      check($sformatf("cyc dut%0d prod", d), 64'(d_prod[d]), 64'(m_prod[d]));
      check($sformatf("cyc dut%0d sign", d), 64'(d_sign[d]), 64'(m_sign[d]));
    end
    if (d_done[0] === 1'b1) ndone0++;
  end

  task automatic pulse8(input logic [7:0] a, input logic [7:0] b);
    md8 = a; mr8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic pulse16(input logic [15:0] a, input logic [15:0] b);
    md16 = a; mr16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // n = 1 is the cycle right after the accepting edge; bounded wait.
  task automatic wait_done(input int d, output int n);
    n = 1;
    while (d_done[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input int d,
                     input int exp_n, input logic [31:0] exp_p, input bit exp_s);
    int n;
    pulse8(a, b);
    wait_done(d, n);
    check({nm, " latency"}, 64'(n), 64'(exp_n));
    check({nm, " product"}, 64'(d_prod[d]), 64'(exp_p));
    check({nm, " sign"},    64'(d_sign[d]), 64'(exp_s));
    $display("op %s md=%02h mr=%02h dut%0d latency=%0d product=%0h sign=%0b",
             nm, a, b, d, n, d_prod[d], d_sign[d]);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int n, base;
    longint rp;
    bit rs;
    int rk;
    logic [15:0] a16, b16;

    rst = 1'b1; start8 = 1'b0; abort8 = 1'b0; md8 = '0; mr8 = '0;
    start16 = 1'b0; md16 = '0; mr16 = '0;
    repeat (3) @(negedge clk);
    check("reset busy",    64'(d_busy[0]), 64'(0));
    check("reset done",    64'(d_done[0]), 64'(0));
    check("reset product", 64'(d_prod[0]), 64'(0));
    check("reset sign",    64'(d_sign[0]), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    op8("10x1",      8'd10,  8'd1,   0, 3,  32'h000A, 1'b0);
    op8("-3x5",      8'hFD,  8'd5,   0, 5,  32'hFFF1, 1'b1);
    check("-3x5 unsigned product", 64'(d_prod[1]), 64'h04F1);
    op8("m128sq",    8'h80,  8'h80,  0, 10, 32'h4000, 1'b0);
    check("m128sq unsigned product", 64'(d_prod[1]), 64'h4000);
    op8("ffxff_u",   8'hFF,  8'hFF,  1, 10, 32'hFE01, 1'b0);
    check("ffxff signed product", 64'(d_prod[0]), 64'h0001);
    op8("mr0_early", 8'h85,  8'h00,  0, 2,  32'h0000, 1'b0);
    op8("mr0_full",  8'h85,  8'h00,  2, 10, 32'h0000, 1'b0);

    // start while busy is ignored
    pulse8(8'd3, 8'h40);
    @(negedge clk);
    pulse8(8'd5, 8'd5);
    wait_done(0, n);
    check("busy_start latency", 64'(n), 64'(7));
    check("busy_start product", 64'(d_prod[0]), 64'h00C0);
    $display("op busy_start latency=%0d product=%0h", n, d_prod[0]);
    repeat (12) @(negedge clk);

    // start in the done cycle is accepted
    base = ndone0;
    pulse8(8'd2, 8'd1);
    wait_done(0, n);
    check("done_start first product", 64'(d_prod[0]), 64'h0002);
    pulse8(8'd4, 8'd3);
    wait_done(0, n);
    check("done_start latency", 64'(n), 64'(4));
    check("done_start product", 64'(d_prod[0]), 64'h000C);
    repeat (12) @(negedge clk);
    check("done_start done count", 64'(ndone0 - base), 64'(2));
    $display("op done_start dones=%0d product=%0h", ndone0 - base, d_prod[0]);

    // abort at E0+3
    base = ndone0;
    pulse8(8'd9, 8'h7F);
    repeat (2) @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    repeat (12) @(negedge clk);
    check("abort done count", 64'(ndone0 - base), 64'(0));
    check("abort product",    64'(d_prod[0]), 64'h000C);
    check("abort busy",       64'(d_busy[0]), 64'(0));
    $display("op abort dones=%0d product=%0h", ndone0 - base, d_prod[0]);

    // asynchronous reset mid-RUN
    pulse8(8'd9, 8'h7F);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy",    64'(d_busy[0]), 64'(0));
    check("async rst done",    64'(d_done[0]), 64'(0));
    check("async rst product", 64'(d_prod[0]), 64'(0));
    check("async rst sign",    64'(d_sign[0]), 64'(0));
    $display("op async_rst busy=%0b product=%0h", d_busy[0], d_prod[0]);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op8("7x6", 8'd7, 8'd6, 0, 5, 32'd42, 1'b0);

    // 16-bit regression
    pulse16(16'h8000, 16'h8000);
    wait_done(3, n);
    check("w16 m32768sq latency", 64'(n), 64'(18));
    check("w16 m32768sq product", 64'(d_prod[3]), 64'h40000000);
    $display("op w16 md=8000 mr=8000 latency=%0d product=%0h", n, d_prod[3]);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      a16 = 16'($urandom);
      b16 = (i % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if (i % 4 == 3) b16 = -b16;
      ref_mult(16, 1'b1, 1'b1, longint'(a16), longint'(b16), rp, rs, rk);
      pulse16(a16, b16);
      wait_done(3, n);
      check("w16 latency", 64'(n), 64'(rk + 2));
      check("w16 product", 64'(d_prod[3]), 64'(rp));
      check("w16 sign",    64'(d_sign[3]), 64'(rs));
      $display("op w16 md=%04h mr=%04h latency=%0d product=%08h sign=%0b",
               a16, b16, n, d_prod[3], d_sign[3]);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
